// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the execute-stage ALU.
// - RV32I op codes {funct7[5],funct3}
// - FSM state encoding
// - single-cycle result helper
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } alu_state_e;

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

  // Single-cycle result. Shift ops only reach here with shamt=0, where
  // the result is the unshifted operand.
  function automatic logic [31:0] alu_single(input logic [3:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    logic [31:0] r;
    case (op)
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_SLT:  r = ($signed(a) < $signed(b)) ? 32'h0000_0001 : 32'h0000_0000;
      ALU_SLTU: r = (a < b) ? 32'h0000_0001 : 32'h0000_0000;
      ALU_XOR:  r = a ^ b;
      ALU_OR:   r = a | b;
      ALU_AND:  r = a & b;
      ALU_SLL,
      ALU_SRL,
      ALU_SRA:  r = a;
      default:  r = 32'h0000_0000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// alu_shifter: serial shifter used for SLL/SRL/SRA.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   load        capture din/amt/op and start shifting
//   din, amt    operand and shift amount (amt > 0 when load)
//   op          shift op code (selects direction and sign fill)
//   result      shreg value after the current step
//   done        this edge performs the final step; result is final
module alu_shifter
  import alu_pkg::*;
#(
  parameter int FAST_SHIFT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] din,
  input  logic [4:0]  amt,
  input  logic [3:0]  op,
  output logic [31:0] result,
  output logic        done
);

  logic [31:0] shreg_r;
  logic [4:0]  count_r;
  logic        left_r;
  logic        fill_r;
  logic [4:0]  step_s;
  logic [31:0] shreg_nxt_s;

  // Step size and next shift-register value.
  always_comb begin
    step_s      = 5'd1;
    shreg_nxt_s = shreg_r;
    if ((FAST_SHIFT != 0) && (count_r >= 5'd4)) begin
      step_s = 5'd4;
    end else begin
      step_s = 5'd1;
    end
    if (left_r) begin
      if (step_s == 5'd4) begin
        shreg_nxt_s = {shreg_r[27:0], 4'b0000};
      end else begin
        shreg_nxt_s = {shreg_r[30:0], 1'b0};
      end
    end else begin
      if (step_s == 5'd4) begin
        shreg_nxt_s = {{4{fill_r}}, shreg_r[31:4]};
      end else begin
        shreg_nxt_s = {fill_r, shreg_r[31:1]};
      end
    end
  end

  assign result = shreg_nxt_s;
  assign done   = (count_r != 5'd0) && (count_r == step_s);

  // Shift register, remaining count and latched direction/fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_r <= 32'h0000_0000;
      count_r <= 5'd0;
      left_r  <= 1'b0;
      fill_r  <= 1'b0;
    end else if (load) begin
      shreg_r <= din;
      count_r <= amt;
      left_r  <= (op == ALU_SLL);
      fill_r  <= (op == ALU_SRA) & din[31];
    end else if (count_r != 5'd0) begin
      shreg_r <= shreg_nxt_s;
      count_r <= count_r - step_s;
    end
  end

endmodule

// File: rtl/alu.sv
// alu: RV32I execute-stage ALU with branch compare flags.
// Ports:
//   I_clk, I_reset_n   clock, async active-low reset
//   I_en               start an operation (only taken while O_busy=0)
//   I_aluop            {funct7[5],funct3}
//   I_dataS1/S2        operands; shamt = I_dataS2[4:0]
//   O_data             result, held until the next operation completes
//   O_busy             high while a serial shift runs
//   O_eq/O_lt/O_ltu    compare flags captured on each accepted I_en
module alu
  import alu_pkg::*;
#(
  parameter int FAST_SHIFT = 1
) (
  input  logic        I_clk,
  input  logic        I_reset_n,
  input  logic        I_en,
  input  logic [3:0]  I_aluop,
  input  logic [31:0] I_dataS1,
  input  logic [31:0] I_dataS2,
  output logic [31:0] O_data,
  output logic        O_busy,
  output logic        O_eq,
  output logic        O_lt,
  output logic        O_ltu
);

  alu_state_e  state_r, state_nxt_s;
  logic [31:0] data_r, data_nxt_s;
  logic        busy_r, busy_nxt_s;
  logic        eq_r, lt_r, ltu_r;
  logic        accept_s;
  logic        shift_start_s;
  logic [31:0] sh_result_s;
  logic        sh_done_s;

  alu_shifter #(
    .FAST_SHIFT(FAST_SHIFT)
  ) u_shifter (
    .clk    (I_clk),
    .rst_n  (I_reset_n),
    .load   (shift_start_s),
    .din    (I_dataS1),
    .amt    (I_dataS2[4:0]),
    .op     (I_aluop),
    .result (sh_result_s),
    .done   (sh_done_s)
  );

  // Next-state and next-output logic for the IDLE/SHIFT FSM.
  always_comb begin
    state_nxt_s   = state_r;
    data_nxt_s    = data_r;
    busy_nxt_s    = busy_r;
    accept_s      = 1'b0;
    shift_start_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (I_en) begin
          accept_s = 1'b1;
          if (is_shift_op(I_aluop) && (I_dataS2[4:0] != 5'd0)) begin
            shift_start_s = 1'b1;
            busy_nxt_s    = 1'b1;
            state_nxt_s   = ST_SHIFT;
          end else begin
            data_nxt_s = alu_single(I_aluop, I_dataS1, I_dataS2);
            busy_nxt_s = 1'b0;
          end
        end else begin
          busy_nxt_s = 1'b0;
        end
      end
      ST_SHIFT: begin
        // New requests are ignored here; the result lands on the last step.
        if (sh_done_s) begin
          data_nxt_s  = sh_result_s;
          busy_nxt_s  = 1'b0;
          state_nxt_s = ST_IDLE;
        end else begin
          busy_nxt_s = 1'b1;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        busy_nxt_s  = 1'b0;
      end
    endcase
  end

  // FSM state, result and busy registers.
  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      state_r <= ST_IDLE;
      data_r  <= 32'h0000_0000;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      data_r  <= data_nxt_s;
      busy_r  <= busy_nxt_s;
    end
  end

  // Compare flags, refreshed on every accepted request (shift starts too).
  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      eq_r  <= 1'b0;
      lt_r  <= 1'b0;
      ltu_r <= 1'b0;
    end else if (accept_s) begin
      eq_r  <= (I_dataS1 == I_dataS2);
      lt_r  <= ($signed(I_dataS1) < $signed(I_dataS2));
      ltu_r <= (I_dataS1 < I_dataS2);
    end
  end

  assign O_data = data_r;
  assign O_busy = busy_r;
  assign O_eq   = eq_r;
  assign O_lt   = lt_r;
  assign O_ltu  = ltu_r;

endmodule

// File: tb/tb_alu.sv
// tb_alu: randomized self-checking bench for alu against a cycle-count /
// final-result reference model, plus directed literal checks.
module tb_alu;

  localparam int FS = 1;

  logic        I_clk;
  logic        I_reset_n;
  logic        I_en;
  logic [3:0]  I_aluop;
  logic [31:0] I_dataS1;
  logic [31:0] I_dataS2;
  logic [31:0] O_data;
  logic        O_busy;
  logic        O_eq;
  logic        O_lt;
  logic        O_ltu;

  int n_cmp = 0;
  int n_bad = 0;

  alu #(.FAST_SHIFT(FS)) dut (
    .I_clk    (I_clk),
    .I_reset_n(I_reset_n),
    .I_en     (I_en),
    .I_aluop  (I_aluop),
    .I_dataS1 (I_dataS1),
    .I_dataS2 (I_dataS2),
    .O_data   (O_data),
    .O_busy   (O_busy),
    .O_eq     (O_eq),
    .O_lt     (O_lt),
    .O_ltu    (O_ltu)
  );

  initial I_clk = 1'b0;
  always #5 I_clk = ~I_clk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_result(input logic [3:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    int unsigned sh;
    sh = b[4:0];
    case (op)
      4'b0000: return a + b;
      4'b1000: return a - b;
      4'b0001: return a << sh;
      4'b0010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0011: return (a < b) ? 32'd1 : 32'd0;
      4'b0100: return a ^ b;
      4'b0101: return a >> sh;
      4'b1101: return 32'($signed(a) >>> sh);
      4'b0110: return a | b;
      4'b0111: return a & b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int busy_cycles(input int n);
    if (FS != 0) return n / 4 + n % 4;
    return n;
  endfunction

  function automatic logic is_shift(input logic [3:0] op);
    return (op == 4'b0001) || (op == 4'b0101) || (op == 4'b1101);
  endfunction

  logic [31:0] m_data, m_pend;
  logic        m_eq, m_lt, m_ltu;
  int          m_left;

  always @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      m_data <= 32'd0; m_pend <= 32'd0; m_left <= 0;
      m_eq <= 1'b0; m_lt <= 1'b0; m_ltu <= 1'b0;
    end else if (m_left != 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) m_data <= m_pend;
    end else if (I_en) begin
      m_eq  <= (I_dataS1 == I_dataS2);
      m_lt  <= ($signed(I_dataS1) < $signed(I_dataS2));
      m_ltu <= (I_dataS1 < I_dataS2);
      if (is_shift(I_aluop) && (I_dataS2[4:0] != 5'd0)) begin
        m_pend <= ref_result(I_aluop, I_dataS1, I_dataS2);
        m_left <= busy_cycles(int'(I_dataS2[4:0]));
      end else begin
        m_data <= ref_result(I_aluop, I_dataS1, I_dataS2);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge I_clk) begin
    check("model_data", O_data, m_data);
    check("model_busy", {31'd0, O_busy}, {31'd0, (m_left != 0)});
    check("model_eq",   {31'd0, O_eq},   {31'd0, m_eq});
    check("model_lt",   {31'd0, O_lt},   {31'd0, m_lt});
    check("model_ltu",  {31'd0, O_ltu},  {31'd0, m_ltu});
  end

  // ---------------- stimulus helpers ----------------
  // Issue one request for one cycle; returns at the negedge after acceptance.
  task automatic op1(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge I_clk);
    I_en = 1'b1; I_aluop = op; I_dataS1 = a; I_dataS2 = b;
    @(negedge I_clk);
    I_en = 1'b0;
  endtask

  // Count negedges with O_busy high, bounded.
  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (O_busy && cnt < 64) begin
      cnt++;
      @(negedge I_clk);
    end
    if (cnt >= 64) check("busy_timeout", 32'd1, 32'd0);
  endtask

  int bc;

  initial begin
    I_reset_n = 1'b1; I_en = 1'b0; I_aluop = 4'd0; I_dataS1 = 32'd0; I_dataS2 = 32'd0;
    #1 I_reset_n = 1'b0;
    repeat (2) @(negedge I_clk);
    check("rst_data", O_data, 32'h0);
    check("rst_busy", {31'd0, O_busy}, 32'h0);
    check("rst_flags", {29'd0, O_eq, O_lt, O_ltu}, 32'h0);
    I_reset_n = 1'b1;

    op1(4'b0000, 32'hFFFF_FFFF, 32'h2);
    check("add_wrap", O_data, 32'h1);
    check("add_nobusy", {31'd0, O_busy}, 32'h0);
    op1(4'b1000, 32'h0, 32'h1);
    check("sub_wrap", O_data, 32'hFFFF_FFFF);
    op1(4'b0010, 32'hFFFF_FFFF, 32'h1);
    check("slt_data", O_data, 32'h1);
    check("slt_flags", {29'd0, O_eq, O_lt, O_ltu}, 32'b010);
    op1(4'b0011, 32'hFFFF_FFFF, 32'h1);
    check("sltu_data", O_data, 32'h0);

    op1(4'b1101, 32'h8000_0000, 32'd7);
    check("sra_hold", O_data, 32'h0);
    wait_idle(bc);
    check("sra_busy", bc, 32'd4);
    check("sra_data", O_data, 32'hFF00_0000);

    op1(4'b0001, 32'h1234_5678, 32'h20);
    check("sll0_busy", {31'd0, O_busy}, 32'h0);
    check("sll0_data", O_data, 32'h1234_5678);

    op1(4'b0101, 32'h8000_0000, 32'd31);
    wait_idle(bc);
    check("srl31_busy", bc, 32'd10);
    check("srl31_data", O_data, 32'h1);

    // ADD issued mid-shift must be ignored.
    op1(4'b0000, 32'd5, 32'd6);
    op1(4'b0101, 32'hF000_0000, 32'd20);
    I_en = 1'b1; I_aluop = 4'b0000; I_dataS1 = 32'd100; I_dataS2 = 32'd200;
    @(negedge I_clk);
    I_en = 1'b0;
    check("midadd_hold", O_data, 32'd11);
    wait_idle(bc);
    check("midadd_busy", bc, 32'd4);
    check("midadd_data", O_data, 32'h0000_0F00);

    // Reset in the middle of a shift.
    op1(4'b0001, 32'h0000_0001, 32'd20);
    @(negedge I_clk);
    #2 I_reset_n = 1'b0;
    #1;
    check("rstmid_busy", {31'd0, O_busy}, 32'h0);
    check("rstmid_data", O_data, 32'h0);
    @(negedge I_clk);
    I_reset_n = 1'b1;
    op1(4'b0000, 32'd3, 32'd4);
    check("post_rst_add", O_data, 32'd7);

    // Randomized traffic, including invalid op codes and ignored requests.
    for (int i = 0; i < 400; i++) begin
      @(negedge I_clk);
      I_en     = ($urandom_range(0, 3) != 0);
      I_aluop  = 4'($urandom_range(0, 15));
      I_dataS1 = $urandom;
      I_dataS2 = $urandom;
      if ($urandom_range(0, 3) == 0) I_dataS2 = I_dataS1;
      if ($urandom_range(0, 2) == 0) I_dataS2[4:0] = 5'($urandom_range(0, 5));
      if (i == 200) begin
        #2 I_reset_n = 1'b0;
        @(negedge I_clk);
        I_reset_n = 1'b1;
      end
    end
    @(negedge I_clk);
    I_en = 1'b0;
    wait_idle(bc);
    repeat (2) @(negedge I_clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
